parking_input_conditioner: RTL and testbench
============================================

Name: parking_input_conditioner

Overview:
Front-end stage that feeds the parking gate controller. It synchronises and debounces the raw entrance and exit sensors and the keypad strobe. It assembles two 2-bit keypad digits into a held password pair (password_1, password_2), which the gate controller compares continuously. All outputs are registered and in the clk domain.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required before a debounced output changes (minimum 1)
DB_W, 3, width of each debounce counter; must hold DEBOUNCE_CYCLES
ENTRY_TIMEOUT, 16, cycles allowed between digit 1 and digit 2 before the entry is discarded
TO_W, 5, width of the timeout counter; must hold ENTRY_TIMEOUT

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
sensor_entrance_raw  input  1  raw entrance sensor (asynchronous, bouncy)
sensor_exit_raw  input  1  raw exit sensor (asynchronous, bouncy)
key_press_raw  input  1  raw keypad strobe (asynchronous, bouncy)
key_value  input  2  keypad digit; stable while key_press_raw is high
key_clear  input  1  synchronous clear request (clk domain, level)
sensor_entrance  output  1  debounced entrance sensor level
sensor_exit  output  1  debounced exit sensor level
password_1  output  2  first digit of the last completed entry
password_2  output  2  second digit of the last completed entry
pass_ready  output  1  one-cycle pulse when a pair completes
entry_timeout  output  1  one-cycle pulse when an entry is abandoned

Behaviour:
- Reset (asynchronous, active-low): all synchroniser flops, debounce outputs, counters, password_1, password_2, pass_ready and entry_timeout go to 0. FSM goes to WAIT_D1.
- Synchronisation: two-flop synchroniser on each of the three raw inputs and on both key_value bits.
- Debounce (per input):
  - Counter clears whenever the synchronised value equals the current output.
  - Counter increments while they differ.
  - When the counter reaches DEBOUNCE_CYCLES, the output takes the synchronised value and the counter clears.
  - Latency from the first sampling edge of a clean transition: DEBOUNCE_CYCLES+2 edges (6 at default).
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Key event: rising edge of the debounced key strobe (one-cycle internal pulse). Digit captured is the synchronised key_value in that cycle.
- FSM states: WAIT_D1, WAIT_D2.
  - WAIT_D1, key event: hold the digit in d1, clear password_1 and password_2 to 2'b00 (no stale valid password survives a new entry), zero the timeout counter, go to WAIT_D2.
  - WAIT_D2, key event: password_1<=d1, password_2<=digit, pass_ready=1 for one cycle, go to WAIT_D1.
  - WAIT_D2, no event: timeout counter increments. When it reaches ENTRY_TIMEOUT: entry_timeout=1 for one cycle, d1 discarded, passwords stay 2'b00, go to WAIT_D1.
  - A key event in the same cycle the count reaches ENTRY_TIMEOUT completes the pair; the event wins and there is no timeout pulse.
- key_clear: password_1, password_2 and d1 go to 0, FSM goes to WAIT_D1, timeout counter clears, no pulses. Takes priority over a key event or timeout in the same cycle. A key event during key_clear is dropped.
- Completed passwords hold indefinitely until the next digit 1, key_clear or reset.
- Sensors are independent of the FSM. Both debounced sensors may be high simultaneously; they are passed through unchanged.

Decomposition:
- Shared package parking_pkg holds:
  - FSM state encoding (WAIT_D1=1'b0, WAIT_D2=1'b1)
  - PASS_W=2 digit width
  - default DEBOUNCE_CYCLES and ENTRY_TIMEOUT constants
- One sub-module, input_debouncer: 2-flop synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES and DB_W. Instantiated three times: entrance, exit, key strobe.

Test Plan:
- Reset mid-entry (after digit 1), then release → all outputs 0, FSM in WAIT_D1, next key event is treated as digit 1.
- sensor_entrance_raw 0→1 held clean → sensor_entrance high exactly 6 edges later. 3-cycle glitch → sensor_entrance stays 0. Bounce 1,0,1,0 then stable 1 → single rise after the last stable run of 4.
- Key 2'b01 then key 2'b10, 5 cycles apart, each held 8 cycles → password_1=01, password_2=10, pass_ready high 1 cycle; values hold 100 cycles with no further keys.
- Key 2'b01, then no key for 16 cycles → entry_timeout pulse, passwords 00/00. A later valid pair 01/10 still completes.
- Completed 01/10, then new digit 2'b11 → passwords drop to 00/00 immediately on the digit 1 event.
- key_clear asserted in the same cycle as the digit-2 key event → passwords 00/00, no pass_ready, FSM WAIT_D1.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: shared constants for the parking gate input front-end
//   PASS_W               keypad digit width
//   DEF_DEBOUNCE_CYCLES  default debounce length in synchronised cycles
//   DEF_ENTRY_TIMEOUT    default cycles allowed between digit 1 and digit 2
//   WAIT_D1 / WAIT_D2    password-entry FSM state encoding
package parking_pkg;
   localparam int PASS_W              = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_ENTRY_TIMEOUT   = 16;
   localparam logic [0:0] WAIT_D1 = 1'b0;
   localparam logic [0:0] WAIT_D2 = 1'b1;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser followed by a stability counter
//   clk, reset_n  clock and asynchronous active-low reset
//   raw_i         asynchronous, bouncy input
//   level_o       registered debounced level
module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DB_W            = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic level_o
);
   localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   logic            s1_q, s2_q, out_q, out_d;
   logic [DB_W-1:0] cnt_q, cnt_d;
   // the cycle that would bring the count to DEBOUNCE_CYCLES flips the output instead
   always_comb begin
      out_d = (s2_q != out_q && cnt_q == LAST) ? s2_q : out_q;
      cnt_d = (s2_q == out_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         out_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         out_q <= out_d;
         cnt_q <= cnt_d;
      end
   end
   assign level_o = out_q;
endmodule

// File: rtl/parking_input_conditioner.sv
// parking_input_conditioner: sensor/keypad conditioning and password pair assembly
//   clk, reset_n                       clock and asynchronous active-low reset
//   sensor_entrance_raw, sensor_exit_raw, key_press_raw   raw asynchronous inputs
//   key_value                          keypad digit, stable while key_press_raw is high
//   key_clear                          synchronous clear of the entry and passwords
//   sensor_entrance, sensor_exit       debounced sensor levels
//   password_1, password_2             last completed digit pair
//   pass_ready, entry_timeout          one-cycle completion / abandon pulses
module parking_input_conditioner
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DB_W            = 3,
   parameter int ENTRY_TIMEOUT   = DEF_ENTRY_TIMEOUT,
   parameter int TO_W            = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sensor_entrance_raw,
   input  logic              sensor_exit_raw,
   input  logic              key_press_raw,
   input  logic [PASS_W-1:0] key_value,
   input  logic              key_clear,
   output logic              sensor_entrance,
   output logic              sensor_exit,
   output logic [PASS_W-1:0] password_1,
   output logic [PASS_W-1:0] password_2,
   output logic              pass_ready,
   output logic              entry_timeout
);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ENTRY_TIMEOUT - 1);
   logic              key_db, key_db_q, key_evt;
   logic [PASS_W-1:0] kv_s1_q, kv_s2_q;
   logic [0:0]        state_q, state_d;
   logic [PASS_W-1:0] d1_q, d1_d, p1_q, p1_d, p2_q, p2_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              pr_q, pr_d, et_q, et_d;
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_ent (
      .clk(clk), .reset_n(reset_n), .raw_i(sensor_entrance_raw), .level_o(sensor_entrance));
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_exit (
      .clk(clk), .reset_n(reset_n), .raw_i(sensor_exit_raw), .level_o(sensor_exit));
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_key (
      .clk(clk), .reset_n(reset_n), .raw_i(key_press_raw), .level_o(key_db));
   assign key_evt = key_db & ~key_db_q;
   // key_clear outranks everything; an event in WAIT_D2 outranks the timeout
   always_comb begin
      state_d = state_q;
      d1_d    = d1_q;
      to_d    = to_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      pr_d    = 1'b0;
      et_d    = 1'b0;
      if (key_clear) begin
         state_d = WAIT_D1;
         d1_d    = '0;
         to_d    = '0;
         p1_d    = '0;
         p2_d    = '0;
      end else if (state_q == WAIT_D1) begin
         if (key_evt) begin
            state_d = WAIT_D2;
            d1_d    = kv_s2_q;
            to_d    = '0;
            p1_d    = '0;
            p2_d    = '0;
         end
      end else if (key_evt) begin
         state_d = WAIT_D1;
         p1_d    = d1_q;
         p2_d    = kv_s2_q;
         pr_d    = 1'b1;
      end else if (to_q == TO_LAST) begin
         state_d = WAIT_D1;
         d1_d    = '0;
         to_d    = '0;
         et_d    = 1'b1;
      end else begin
         to_d = to_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kv_s1_q  <= '0;
         kv_s2_q  <= '0;
         key_db_q <= 1'b0;
         state_q  <= WAIT_D1;
         d1_q     <= '0;
         to_q     <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         pr_q     <= 1'b0;
         et_q     <= 1'b0;
      end else begin
         kv_s1_q  <= key_value;
         kv_s2_q  <= kv_s1_q;
         key_db_q <= key_db;
         state_q  <= state_d;
         d1_q     <= d1_d;
         to_q     <= to_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         pr_q     <= pr_d;
         et_q     <= et_d;
      end
   end
   assign password_1    = p1_q;
   assign password_2    = p2_q;
   assign pass_ready    = pr_q;
   assign entry_timeout = et_q;
endmodule

// File: tb/tb_parking_input_conditioner.sv
// tb_parking_input_conditioner: directed self-checking bench for parking_input_conditioner
module tb_parking_input_conditioner;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ent_raw = 1'b0, exit_raw = 1'b0, key_raw = 1'b0, key_clear = 1'b0;
   logic [1:0] key_value = 2'b00;
   logic       sensor_entrance, sensor_exit, pass_ready, entry_timeout;
   logic [1:0] password_1, password_2;
   int         n_chk = 0, n_err = 0, n_pr = 0, n_to = 0;

   parking_input_conditioner dut (
      .clk(clk), .reset_n(reset_n),
      .sensor_entrance_raw(ent_raw), .sensor_exit_raw(exit_raw),
      .key_press_raw(key_raw), .key_value(key_value), .key_clear(key_clear),
      .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
      .password_1(password_1), .password_2(password_2),
      .pass_ready(pass_ready), .entry_timeout(entry_timeout));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pass_ready) n_pr++;
      if (entry_timeout) n_to++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // holds the key for 8 edges; the event registers on edge 7 after the press starts
   task automatic press(input logic [1:0] v, input logic exp_pr, input int clr_at);
      @(posedge clk);
      #1;
      key_value = v;
      key_raw   = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         key_clear = (i == clr_at);
         if (i == 6) check("pr_before_event", pass_ready, 0);
         if (i == 7) check("pr_on_event", pass_ready, exp_pr);
      end
      key_raw   = 1'b0;
      key_clear = 1'b0;
   endtask

   task automatic check_pw(input string tag, input logic [1:0] e1, input logic [1:0] e2);
      check({tag, "_p1"}, password_1, e1);
      check({tag, "_p2"}, password_2, e2);
   endtask

   initial begin
      logic seen;
      idle(3);
      check("rst_ent", sensor_entrance, 0);
      check("rst_exit", sensor_exit, 0);
      check_pw("rst", 2'b00, 2'b00);
      check("rst_pr", pass_ready, 0);
      check("rst_to", entry_timeout, 0);
      reset_n = 1'b1;
      idle(2);
      // 3-cycle glitch must be rejected
      ent_raw = 1'b1;
      idle(3);
      ent_raw = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         idle(1);
         seen |= sensor_entrance;
      end
      check("ent_glitch", seen, 0);
      // clean rise: high exactly 6 edges later
      ent_raw = 1'b1;
      idle(5);
      check("ent_early", sensor_entrance, 0);
      idle(1);
      check("ent_rise", sensor_entrance, 1);
      // bounce 1,0,1,0 then stable 1 on exit
      exit_raw = 1'b1; idle(1);
      exit_raw = 1'b0; idle(1);
      exit_raw = 1'b1; idle(1);
      exit_raw = 1'b0; idle(1);
      exit_raw = 1'b1;
      idle(5);
      check("exit_early", sensor_exit, 0);
      idle(1);
      check("exit_rise", sensor_exit, 1);
      check("both_high_ent", sensor_entrance, 1);
      // pair 01 / 10
      press(2'b01, 0, 0);
      idle(5);
      press(2'b10, 1, 0);
      check_pw("pair1", 2'b01, 2'b10);
      check("pair1_cnt", n_pr, 1);
      idle(100);
      check_pw("hold", 2'b01, 2'b10);
      check("hold_cnt", n_pr, 1);
      // abandoned entry: timeout 16 edges after the digit-1 event
      press(2'b01, 0, 0);
      check_pw("d1_clears", 2'b00, 2'b00);
      idle(14);
      check("to_early", entry_timeout, 0);
      idle(1);
      check("to_pulse", entry_timeout, 1);
      idle(1);
      check("to_width", entry_timeout, 0);
      check_pw("to", 2'b00, 2'b00);
      press(2'b01, 0, 0);
      idle(5);
      press(2'b10, 1, 0);
      check_pw("pair2", 2'b01, 2'b10);
      // new digit 1 wipes the completed pair
      idle(5);
      press(2'b11, 0, 0);
      check_pw("new_d1", 2'b00, 2'b00);
      // key_clear coincident with the digit-2 event
      idle(5);
      press(2'b10, 0, 6);
      check_pw("clr", 2'b00, 2'b00);
      check("clr_cnt", n_pr, 2);
      idle(5);
      press(2'b11, 0, 0);
      check_pw("clr_d1", 2'b00, 2'b00);
      idle(5);
      press(2'b10, 1, 0);
      check_pw("pair3", 2'b11, 2'b10);
      // reset mid-entry
      idle(5);
      press(2'b01, 0, 0);
      idle(2);
      reset_n = 1'b0;
      #1;
      check("arst_ent", sensor_entrance, 0);
      check("arst_exit", sensor_exit, 0);
      check_pw("arst", 2'b00, 2'b00);
      idle(2);
      reset_n = 1'b1;
      idle(5);
      press(2'b10, 0, 0);
      idle(5);
      press(2'b11, 1, 0);
      check_pw("pair4", 2'b10, 2'b11);
      check("sens_back", {sensor_entrance, sensor_exit}, 2'b11);
      check("total_pr", n_pr, 4);
      check("total_to", n_to, 1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
